// File: rtl/apb_completer_mem.sv
// APB completer with per-slave register-backed word memory and an in-line
// protocol checker (sticky error flag, first-error code, transfer counters).
//
// Bus handshake: there is no pready, so the completer is always ready. A
// transfer is one setup cycle (exactly one pselx bit set, penable=0)
// followed by one access cycle (same pselx/paddr/pwrite, penable=1). The
// transfer completes on the clock edge that ends the access cycle. Read
// data is registered on the edge that ends setup and is held through access.
//
// State encoding names the phase the bus has just completed:
//   ST_IDLE   - no transfer in flight
//   ST_SETUP  - a valid setup was captured; this cycle must be its access
//   ST_ACCESS - an access just completed; this cycle behaves like idle
module apb_completer_mem #(
    parameter int NSLV     = 4,
    parameter int DEPTH    = 16,
    parameter int ADDR_LSB = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSLV-1:0]   pselx,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              perr,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [1:0]        dbg_state_o
);

    localparam int WW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW        = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int IW        = BW + WW;
    localparam int MEM_WORDS = 1 << IW;

    localparam logic [1:0] ERR_ENABLE = 2'd1;
    localparam logic [1:0] ERR_MULTI  = 2'd2;
    localparam logic [1:0] ERR_MATCH  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NSLV-1:0]   cap_sel_q, cap_sel_d;
    logic [31:0]       cap_addr_q, cap_addr_d;
    logic              cap_write_q, cap_write_d;
    logic [31:0]       prdata_q;
    logic              perr_q;
    logic [1:0]        err_code_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  rd_count_q;
    logic [31:0]       mem_q [MEM_WORDS];

    logic              multi_sel;
    logic              load_rd;
    logic              commit;
    logic              err_hit;
    logic [1:0]        err_new;
    logic [IW-1:0]     bus_idx;
    logic [IW-1:0]     cap_idx;

    // Position of the (last) set bit; callers only use it for one-hot values.
    function automatic logic [BW-1:0] onehot_idx(input logic [NSLV-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (v[i]) onehot_idx = BW'(i);
        end
    endfunction

    assign multi_sel = (pselx & (pselx - NSLV'(1))) != '0;
    assign bus_idx   = {onehot_idx(pselx), paddr[ADDR_LSB +: WW]};
    assign cap_idx   = {onehot_idx(cap_sel_q), cap_addr_q[ADDR_LSB +: WW]};

    // Next-state, capture and error classification for the current bus cycle.
    always_comb begin
        state_d     = state_q;
        cap_sel_d   = cap_sel_q;
        cap_addr_d  = cap_addr_q;
        cap_write_d = cap_write_q;
        load_rd     = 1'b0;
        commit      = 1'b0;
        err_hit     = 1'b0;
        err_new     = 2'd0;
        case (state_q)
            ST_SETUP: begin
                if (multi_sel) begin
                    err_hit = 1'b1;
                    err_new = ERR_MULTI;
                    state_d = ST_IDLE;
                end else if (penable && (pselx == cap_sel_q) &&
                             (paddr == cap_addr_q) && (pwrite == cap_write_q)) begin
                    commit  = 1'b1;
                    state_d = ST_ACCESS;
                end else begin
                    err_hit = 1'b1;
                    err_new = ERR_MATCH;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Idle and just-completed access decode identically: a new
                // setup may follow immediately, a repeated enable is an error.
                if (multi_sel) begin
                    err_hit = 1'b1;
                    err_new = ERR_MULTI;
                    state_d = ST_IDLE;
                end else if ((|pselx) && !penable) begin
                    cap_sel_d   = pselx;
                    cap_addr_d  = paddr;
                    cap_write_d = pwrite;
                    load_rd     = !pwrite;
                    state_d     = ST_SETUP;
                end else if (penable) begin
                    err_hit = 1'b1;
                    err_new = ERR_ENABLE;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State, captured setup fields, read data, error and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cap_sel_q   <= '0;
            cap_addr_q  <= '0;
            cap_write_q <= 1'b0;
            prdata_q    <= '0;
            perr_q      <= 1'b0;
            err_code_q  <= 2'd0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cap_sel_q   <= cap_sel_d;
            cap_addr_q  <= cap_addr_d;
            cap_write_q <= cap_write_d;
            if (load_rd) prdata_q <= mem_q[bus_idx];
            if (err_hit && !perr_q) begin
                perr_q     <= 1'b1;
                err_code_q <= err_new;
            end
            if (commit && cap_write_q && (wr_count_q != {CNT_W{1'b1}}))
                wr_count_q <= wr_count_q + CNT_W'(1);
            if (commit && !cap_write_q && (rd_count_q != {CNT_W{1'b1}}))
                rd_count_q <= rd_count_q + CNT_W'(1);
        end
    end

    // Word memory: written only when a write access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (commit && cap_write_q) begin
            mem_q[cap_idx] <= pwdata;
        end
    end

    assign prdata      = prdata_q;
    assign perr        = perr_q;
    assign err_code    = err_code_q;
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;
    assign dbg_state_o = state_q;

endmodule
